// File: rtl/mul_pkg.sv
// Shared definitions for the mul_accum block: controller state encoding and
// default widths for the accumulator, run-length field and incoming product.
package mul_pkg;

  localparam int unsigned ACC_W  = 12;  // accumulator / result width
  localparam int unsigned LEN_W  = 4;   // products-per-run field width
  localparam int unsigned PROD_W = 8;   // product width from the 4x4 multiplier

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mul_accum_if.sv
// Product-in / result-out handshake bundle for mul_accum.
//   prod_in/prod_valid/prod_ready : upstream product stream (valid/ready)
//   acc_out/out_valid/out_ready   : downstream result (valid/ready)
// master: the environment side (drives products, consumes results)
// slave : the mul_accum side
interface mul_accum_if #(
  parameter int unsigned ACC_W = mul_pkg::ACC_W
);
  import mul_pkg::*;

  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output prod_in, prod_valid, out_ready,
    input  prod_ready, acc_out, out_valid
  );

  modport slave (
    input  prod_in, prod_valid, out_ready,
    output prod_ready, acc_out, out_valid
  );

endinterface

// File: rtl/mul_accum_cnt.sv
// Run-length down-counter for mul_accum.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   ena      : global enable; low freezes the count
//   load     : load len (len=0 loads 2^LEN_W)
//   len      : run length
//   dec      : decrement by one (ignored while loading or at zero)
//   last     : count equals one, i.e. the next decrement finishes the run
module mul_accum_cnt #(
  parameter int unsigned LEN_W = mul_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             dec,
  output logic             last
);
  import mul_pkg::*;

  // One extra bit so a full 2^LEN_W run is representable.
  localparam logic [LEN_W:0] FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] ONE  = {{LEN_W{1'b0}}, 1'b1};

  logic [LEN_W:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ena) begin
      if (load) begin
        cnt <= (len == '0) ? FULL : {1'b0, len};
      end else if (dec && cnt != '0) begin
        cnt <= cnt - ONE;
      end
    end
  end

  assign last = (cnt == ONE);

endmodule

// File: rtl/mul_accum.sv
// Multiply-accumulate back end: sums a run of len unsigned 8-bit products
// (len=0 means 2^LEN_W) into an ACC_W-bit modulo accumulator and presents
// the result with a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   ena      : global enable; low freezes all state and blocks handshakes
//   start    : begin a run (only honoured in IDLE)
//   len      : products per run, latched on an accepted start
//   bus      : product input and result output handshakes
//   busy     : high whenever not IDLE
module mul_accum #(
  parameter int unsigned ACC_W = mul_pkg::ACC_W,
  parameter int unsigned LEN_W = mul_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  mul_accum_if.slave       bus,
  output logic             busy
);
  import mul_pkg::*;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc;
  logic             start_ok;
  logic             accept;
  logic             last;

  assign start_ok       = ena && start && (state_q == IDLE);
  assign bus.prod_ready = ena && (state_q == ACCUM);
  assign accept         = bus.prod_ready && bus.prod_valid;

  mul_accum_cnt #(
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .load (start_ok),
    .len  (len),
    .dec  (accept),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = ACCUM;
      ACCUM:   if (accept && last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator wraps modulo 2^ACC_W; it is only cleared by reset or a new
  // run, so the previous result stays visible through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (ena) begin
      if (start_ok) begin
        acc <= '0;
      end else if (accept) begin
        acc <= acc + ACC_W'(bus.prod_in);
      end
    end
  end

  assign bus.acc_out   = acc;
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mul_accum.sv
// Directed self-checking bench for mul_accum.
module tb_mul_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       start;
  logic [3:0] len;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mul_accum_if #(.ACC_W(12)) bus ();

  mul_accum #(
    .ACC_W(12),
    .LEN_W(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .start (start),
    .len   (len),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; start = 1'b0; len = 4'd0;
    bus.prod_in = 8'd0; bus.prod_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (bus.acc_out !== 12'd0) begin n_fail++; $display("FAIL reset_acc got %0d want 0", bus.acc_out); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.prod_ready !== 1'b0) begin n_fail++; $display("FAIL reset_prod_ready got %b want 0", bus.prod_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_short_run();
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL short_busy got %b want 1", busy); end
    n_checks++; if (bus.acc_out !== 12'd0) begin n_fail++; $display("FAIL short_clear got %0d want 0", bus.acc_out); end
    for (int i = 0; i < 3; i++) begin
      bus.prod_valid = 1'b1; bus.prod_in = 8'd225;
      n_checks++; if (bus.prod_ready !== 1'b1) begin n_fail++; $display("FAIL short_ready[%0d] got %b want 1", i, bus.prod_ready); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL short_early_valid[%0d] got %b want 0", i, bus.out_valid); end
      tick();
    end
    bus.prod_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid got %b want 1", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 12'h2A3) begin n_fail++; $display("FAIL short_sum got %0d want 675", bus.acc_out); end
    n_checks++; if (bus.prod_ready !== 1'b0) begin n_fail++; $display("FAIL short_ready_done got %b want 0", bus.prod_ready); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL short_idle got busy=%b want 0", busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL short_valid_drop got %b want 0", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 12'd675) begin n_fail++; $display("FAIL short_hold_idle got %0d want 675", bus.acc_out); end
  endtask

  task automatic test_full_run();
    int unsigned early = 0;
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.prod_valid = 1'b1; bus.prod_in = 8'd225;
      if (bus.out_valid !== 1'b0) early++;
      tick();
    end
    bus.prod_valid = 1'b0;
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL full_premature_valid got %0d cycles want 0", early); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b want 1", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 12'hE10) begin n_fail++; $display("FAIL full_sum got %0d want 3600", bus.acc_out); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_stalls();
    start = 1'b1; len = 4'd2;
    tick();
    start = 1'b0;
    bus.prod_valid = 1'b1; bus.prod_in = 8'd20;
    tick();
    // valid gap with junk on the data lines
    bus.prod_valid = 1'b0; bus.prod_in = 8'd99;
    tick(); tick(); tick();
    n_checks++; if (bus.acc_out !== 12'd20) begin n_fail++; $display("FAIL stall_gap_sum got %0d want 20", bus.acc_out); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_gap_valid got %b want 0", bus.out_valid); end
    ena = 1'b0; bus.prod_valid = 1'b1; bus.prod_in = 8'd21;
    #1;
    n_checks++; if (bus.prod_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ena_ready got %b want 0", bus.prod_ready); end
    tick(); tick();
    n_checks++; if (bus.acc_out !== 12'd20) begin n_fail++; $display("FAIL stall_ena_sum got %0d want 20", bus.acc_out); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_ena_busy got %b want 1", busy); end
    ena = 1'b1;
    #1;
    n_checks++; if (bus.prod_ready !== 1'b1) begin n_fail++; $display("FAIL stall_resume_ready got %b want 1", bus.prod_ready); end
    tick();
    bus.prod_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b want 1", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 12'd41) begin n_fail++; $display("FAIL stall_sum got %0d want 41", bus.acc_out); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int unsigned bad = 0;
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    bus.prod_valid = 1'b1; bus.prod_in = 8'd225;
    tick(); tick(); tick();
    bus.prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 4'd1;
      tick();
      if (bus.out_valid !== 1'b1 || bus.acc_out !== 12'd675 || busy !== 1'b1) bad++;
    end
    start = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    // out_ready without ena must not complete the handshake
    ena = 1'b0; bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_ena_hold got %b want 1", bus.out_valid); end
    ena = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got busy=%b want 0", busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_midrun_reset();
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    bus.prod_valid = 1'b1; bus.prod_in = 8'd100;
    tick();
    bus.prod_in = 8'd50;
    tick();
    bus.prod_valid = 1'b0;
    n_checks++; if (bus.acc_out !== 12'd150) begin n_fail++; $display("FAIL mid_partial got %0d want 150", bus.acc_out); end
    // reset wins over a simultaneous product
    rst = 1'b1; bus.prod_valid = 1'b1; bus.prod_in = 8'd7;
    tick();
    rst = 1'b0; bus.prod_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_checks++; if (bus.acc_out !== 12'd0) begin n_fail++; $display("FAIL mid_rst_acc got %0d want 0", bus.acc_out); end
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    bus.prod_valid = 1'b1; bus.prod_in = 8'd9;
    tick();
    bus.prod_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_new_valid got %b want 1", bus.out_valid); end
    n_checks++; if (bus.acc_out !== 12'd9) begin n_fail++; $display("FAIL mid_new_sum got %0d want 9", bus.acc_out); end
    // reset wins over a simultaneous out_ready/start
    rst = 1'b1; bus.out_ready = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; bus.out_ready = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0 || bus.acc_out !== 12'd0) begin n_fail++; $display("FAIL rst_priority got busy=%b acc=%0d want 0/0", busy, bus.acc_out); end
  endtask

  initial begin
    test_reset();
    test_short_run();
    test_full_run();
    test_stalls();
    test_backpressure();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_accum.md
MUL_ACCUM -- requirements
Module: mul_accum

Interface
REQ-001 Parameter: ACC_W, 12, accumulator/result width in bits.
REQ-002 Parameter: LEN_W, 4, width of the products-per-run field.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: ena  input  1  global enable; low freezes all state and blocks all handshakes.
REQ-006 Port: start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 Port: len  input  LEN_W  products per run, latched on accepted start; 0 means 2^LEN_W.
REQ-008 Port: prod_in  input  8  unsigned product from the upstream 4x4 add-tree multiplier.
REQ-009 Port: prod_valid  input  1  prod_in is valid this cycle.
REQ-010 Port: prod_ready  output  1  block accepts prod_in this cycle.
REQ-011 Port: acc_out  output  ACC_W  accumulated sum of the run.
REQ-012 Port: out_valid  output  1  acc_out holds a completed result.
REQ-013 Port: out_ready  input  1  downstream consumes the result.
REQ-014 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL have three states: IDLE, ACCUM and DONE.
REQ-016 IDLE -> ACCUM SHALL occur when ena=1 and start=1; in that cycle the accumulator clears to 0, the counter loads len, and len=0 loads 2^LEN_W.
REQ-017 start SHALL be ignored in ACCUM and DONE.
REQ-018 prod_ready SHALL be 1 only when state=ACCUM and ena=1.
REQ-019 A product SHALL be accepted only on a cycle with prod_valid=1 and prod_ready=1; on acceptance the accumulator adds zero-extended prod_in and the counter decrements.
REQ-020 Accumulation SHALL be modulo 2^ACC_W; no saturation and no overflow flag. At the defaults the worst case is 16*225=3600, so no wrap occurs.
REQ-021 When the accepted product is the last one (counter=1), the state SHALL move to DONE on that edge, and out_valid SHALL be 1 in the next cycle (latency 1 cycle).
REQ-022 In DONE, out_valid=1 and acc_out SHALL hold stable until a cycle with out_ready=1 and ena=1; on that edge the state returns to IDLE.
REQ-023 out_valid SHALL be 0 in IDLE and ACCUM.
REQ-024 acc_out SHALL keep its last value in IDLE until the next accepted start clears it.
REQ-025 Gaps in prod_valid SHALL stall accumulation with no loss or duplication.
REQ-026 With ena=0, no register SHALL change and prod_ready SHALL be 0; out_valid SHALL hold its value.
REQ-027 If rst and any other event occur in the same cycle, rst SHALL take priority.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set state=IDLE, accumulator=0 and counter=0.
REQ-029 After reset, acc_out=0, out_valid=0, prod_ready=0 and busy=0.
REQ-030 Reset mid-ACCUM or mid-DONE SHALL abandon the run; the partial sum is not retained.

Structure
REQ-031 Shared package mul_pkg SHALL hold the state enumeration, ACC_W, LEN_W, and the 8-bit product width constant.
REQ-032 One sub-module, mul_accum_cnt, SHALL implement the run-length down-counter with load, decrement and last flag.
REQ-033 All logic SHALL run on clk only, with no latches.

Verification
REQ-034 Reset: hold rst=1 for 2 cycles -> acc_out=0, out_valid=0, prod_ready=0, busy=0.
REQ-035 Short run: start with len=3, then three products of 225 back-to-back -> out_valid rises 1 cycle after the third acceptance, acc_out=675 (0x2A3).
REQ-036 Full run: start with len=0, then 16 products of 225 -> acc_out=3600 (0xE10), with no premature out_valid.
REQ-037 Stalls: len=2, products 20 and 21, with prod_valid gaps of 3 cycles and ena=0 for 2 cycles between them -> acc_out=41, and prod_ready=0 while ena=0.
REQ-038 Backpressure: result 675 in DONE, out_ready=0 for 5 cycles, start pulsed -> acc_out stays 675, out_valid stays 1, start is ignored; out_ready=1 -> IDLE next cycle.
REQ-039 Mid-run reset: len=4, two products accepted, rst=1 for 1 cycle -> IDLE, acc_out=0; a new len=1 run with product 9 -> acc_out=9.
